graphics_robot: RTL and testbench
=================================

Name: graphics_robot

Overview:
- Next-generation pixel generator for the pipe-cleaning robot VGA display.
- Draws a parametrised wall column, a movable square robot sprite and a background.
- The robot's position is held in registers and updated once per frame from direction commands; the robot blinks while cleaning.
- Sits between the VGA sync generator (video_on, pix_x, pix_y) and the RGB output pins; the pixel output is registered.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- WALL_X_L, 32, wall column left edge (inclusive)
- WALL_X_R, 35, wall column right edge (inclusive)
- ROBOT_W, 16, robot sprite side length in pixels
- ROBOT_STEP, 2, pixels moved per accepted command
- ROBOT_X0, 64, robot left edge after reset
- ROBOT_Y0, 232, robot top edge after reset
- BLINK_FRAMES, 16, blink period in frames (even, >=2)
- WALL_RGB, 3'b001, wall colour
- ROBOT_RGB, 3'b100, robot colour when idle or in blink phase 0
- CLEAN_RGB, 3'b010, robot colour in blink phase 1
- BG_RGB, 3'b110, background colour

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- video_on  in  1  high inside the visible area
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- dir_valid  in  1  single-cycle direction command strobe
- dir  in  2  direction: 00 right, 01 left, 10 down, 11 up
- clean_en  in  1  cleaning mode; enables blinking
- graph_rgb  out  3  registered pixel colour
- robot_x  out  10  robot left edge
- robot_y  out  10  robot top edge
- frame_tick  out  1  one-cycle pulse per frame
- blocked  out  1  last move was clamped at a limit

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. Asserting rst_n at any time, including mid-frame, immediately forces:
  - graph_rgb=000, robot_x=ROBOT_X0, robot_y=ROBOT_Y0
  - frame_tick=0, blocked=0
  - pending command cleared, blink counter=0
- Frame tick:
  - cond = (pix_x==0 && pix_y==V_VISIBLE).
  - frame_tick is registered and asserts for exactly one clk on the rising edge of cond (cond && !cond_d).
  - It fires once per frame even if pix_x/pix_y are held for several clks (pixel enable slower than clk).
- Command buffer:
  - dir_valid latches dir into a one-entry pending register; the last command before a tick wins.
  - At frame_tick the pending command is consumed and cleared.
  - dir_valid on the same clk as frame_tick: the tick consumes the previously pending command; the new command becomes pending for the next frame.
- Move, computed at frame_tick with a pending command, using 11-bit intermediates:
  - Limits: x_min=WALL_X_R+1, x_max=H_VISIBLE-ROBOT_W, y_min=0, y_max=V_VISIBLE-ROBOT_W.
  - Candidate = position ±ROBOT_STEP on one axis.
  - If the candidate is beyond a limit, the position saturates at that limit and blocked=1; otherwise the position takes the candidate and blocked=0.
  - Subtraction checks the limit before subtracting, so there is no underflow.
  - A robot already at the limit and commanded further stays put, blocked=1.
  - blocked changes only on consumed commands.
- Position update timing: only on the frame_tick clk. This is outside the visible area, so there is no tearing.
- Blink:
  - While clean_en=1, the counter increments on each frame_tick, wrapping from BLINK_FRAMES-1 to 0.
  - Phase 0 (counter < BLINK_FRAMES/2) draws ROBOT_RGB; phase 1 draws CLEAN_RGB.
  - clean_en=0 resets the counter synchronously to 0 (colour ROBOT_RGB).
- Rendering:
  - wall_on = WALL_X_L<=pix_x<=WALL_X_R.
  - robot_on = robot_x<=pix_x<=robot_x+ROBOT_W-1 and robot_y<=pix_y<=robot_y+ROBOT_W-1.
  - Priority: !video_on -> 000; robot_on -> robot colour; wall_on -> WALL_RGB; else BG_RGB.
  - Result is registered; latency is 1 clk from pix_x/pix_y/video_on to graph_rgb.
- Invariant: robot_x never enters [WALL_X_L, WALL_X_R], and robot_x/robot_y stay within the visible area.

Test Plan:
- Reset mid-frame with rst_n=0 -> graph_rgb=000, robot_x=64, robot_y=232, blocked=0 with no clk edge; sample pix (70,240) video_on=1 one clk after release -> graph_rgb=100.
- Raster scan, clean_en=0 -> pix_x=33 gives 001; pix (100,100) gives 110; video_on=0 gives 000; each value appears 1 clk after its inputs.
- dir_valid dir=00, then one frame -> exactly one frame_tick per frame with pix held 2 clks; robot_x=66 after the tick; no further motion on the next frame.
- dir=01 repeated from robot_x=38 -> 36 blocked=0, then 36 blocked=1; dir=11 from robot_y=1 -> 0 blocked=1; dir=10 at robot_y=464 -> stays 464 blocked=1.
- Two dir_valid pulses (00 then 10) in one frame -> only down applied: robot_y+=2, robot_x unchanged. dir_valid coincident with frame_tick -> applied on the following tick.
- clean_en=1 for 16 frames -> robot pixel colour 100 for ticks 0-7 and 010 for ticks 8-15, then repeats; dropping clean_en -> 100 next clk.

Source files
------------

// File: rtl/graphics_robot.sv
// Pixel generator for the pipe-cleaning robot display: wall column, robot sprite and background.
// Robot position moves once per frame from buffered direction commands and blinks while cleaning.
module graphics_robot #(
    parameter int          H_VISIBLE    = 640,
    parameter int          V_VISIBLE    = 480,
    parameter int          WALL_X_L     = 32,
    parameter int          WALL_X_R     = 35,
    parameter int          ROBOT_W      = 16,
    parameter int          ROBOT_STEP   = 2,
    parameter int          ROBOT_X0     = 64,
    parameter int          ROBOT_Y0     = 232,
    parameter int          BLINK_FRAMES = 16,
    parameter logic [2:0]  WALL_RGB     = 3'b001,
    parameter logic [2:0]  ROBOT_RGB    = 3'b100,
    parameter logic [2:0]  CLEAN_RGB    = 3'b010,
    parameter logic [2:0]  BG_RGB       = 3'b110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       video_on,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic       clean_en,
    output logic [2:0] graph_rgb,
    output logic [9:0] robot_x,
    output logic [9:0] robot_y,
    output logic       frame_tick,
    output logic       blocked
);

    localparam int BLINK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0] X_MIN   = 11'(WALL_X_R + 1);
    localparam logic [10:0] X_MAX   = 11'(H_VISIBLE - ROBOT_W);
    localparam logic [10:0] Y_MIN   = 11'd0;
    localparam logic [10:0] Y_MAX   = 11'(V_VISIBLE - ROBOT_W);
    localparam logic [10:0] STEP    = 11'(ROBOT_STEP);
    localparam logic [10:0] SIZE_M1 = 11'(ROBOT_W - 1);
    localparam logic [9:0]  WALL_L  = 10'(WALL_X_L);
    localparam logic [9:0]  WALL_R  = 10'(WALL_X_R);
    localparam logic [9:0]  TICK_Y  = 10'(V_VISIBLE);
    localparam logic [9:0]  X0      = 10'(ROBOT_X0);
    localparam logic [9:0]  Y0      = 10'(ROBOT_Y0);

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_FRAMES / 2);

    logic               cond;
    logic               cond_d_reg;
    logic               frame_tick_reg;
    logic               pend_valid_reg;
    logic [1:0]         pend_dir_reg;
    logic [9:0]         x_reg, x_next;
    logic [9:0]         y_reg, y_next;
    logic               blocked_reg, blocked_next;
    logic [BLINK_W-1:0] blink_reg;
    logic [2:0]         rgb_reg, rgb_next;
    logic [10:0]        x_ext, y_ext, cand;
    logic               wall_on, robot_on;
    logic [2:0]         robot_rgb;

    // Rising-edge detect so a pixel position held for several clocks still gives one tick.
    assign cond = (pix_x == 10'd0) && (pix_y == TICK_Y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_d_reg     <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            cond_d_reg     <= cond;
            frame_tick_reg <= cond && !cond_d_reg;
        end
    end

    // A command arriving on the tick clock survives: the tick consumes the older one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_reg <= 1'b0;
            pend_dir_reg   <= 2'b00;
        end else if (dir_valid) begin
            pend_valid_reg <= 1'b1;
            pend_dir_reg   <= dir;
        end else if (frame_tick_reg) begin
            pend_valid_reg <= 1'b0;
        end
    end

    // Saturating move; decrements compare against the limit first so nothing wraps.
    always_comb begin
        x_ext        = {1'b0, x_reg};
        y_ext        = {1'b0, y_reg};
        cand         = 11'd0;
        x_next       = x_reg;
        y_next       = y_reg;
        blocked_next = blocked_reg;
        case (pend_dir_reg)
            2'b00: begin
                cand = x_ext + STEP;
                if (cand > X_MAX) begin
                    x_next       = X_MAX[9:0];
                    blocked_next = 1'b1;
                end else begin
                    x_next       = cand[9:0];
                    blocked_next = 1'b0;
                end
            end
            2'b01: begin
                if (x_ext < X_MIN + STEP) begin
                    x_next       = X_MIN[9:0];
                    blocked_next = 1'b1;
                end else begin
                    cand         = x_ext - STEP;
                    x_next       = cand[9:0];
                    blocked_next = 1'b0;
                end
            end
            2'b10: begin
                cand = y_ext + STEP;
                if (cand > Y_MAX) begin
                    y_next       = Y_MAX[9:0];
                    blocked_next = 1'b1;
                end else begin
                    y_next       = cand[9:0];
                    blocked_next = 1'b0;
                end
            end
            default: begin
                if (y_ext < Y_MIN + STEP) begin
                    y_next       = Y_MIN[9:0];
                    blocked_next = 1'b1;
                end else begin
                    cand         = y_ext - STEP;
                    y_next       = cand[9:0];
                    blocked_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg       <= X0;
            y_reg       <= Y0;
            blocked_reg <= 1'b0;
        end else if (frame_tick_reg && pend_valid_reg) begin
            x_reg       <= x_next;
            y_reg       <= y_next;
            blocked_reg <= blocked_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_reg <= '0;
        end else if (!clean_en) begin
            blink_reg <= '0;
        end else if (frame_tick_reg) begin
            blink_reg <= (blink_reg == BLINK_LAST) ? '0 : blink_reg + 1'b1;
        end
    end

    // Gating with clean_en lets the idle colour appear on the clock right after cleaning stops.
    assign robot_rgb = (clean_en && (blink_reg >= BLINK_HALF)) ? CLEAN_RGB : ROBOT_RGB;

    assign wall_on  = (pix_x >= WALL_L) && (pix_x <= WALL_R);
    assign robot_on = ({1'b0, pix_x} >= {1'b0, x_reg}) &&
                      ({1'b0, pix_x} <= {1'b0, x_reg} + SIZE_M1) &&
                      ({1'b0, pix_y} >= {1'b0, y_reg}) &&
                      ({1'b0, pix_y} <= {1'b0, y_reg} + SIZE_M1);

    always_comb begin
        rgb_next = BG_RGB;
        if (!video_on)
            rgb_next = 3'b000;
        else if (robot_on)
            rgb_next = robot_rgb;
        else if (wall_on)
            rgb_next = WALL_RGB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb_reg <= 3'b000;
        else
            rgb_reg <= rgb_next;
    end

    assign graph_rgb  = rgb_reg;
    assign robot_x    = x_reg;
    assign robot_y    = y_reg;
    assign frame_tick = frame_tick_reg;
    assign blocked    = blocked_reg;

endmodule

// File: tb/tb_graphics_robot.sv
// Scoreboard bench for graphics_robot: stimulus pushes expected outputs per clock,
// a monitor pops and compares them one clock later.
module tb_graphics_robot;

    localparam int X_MIN = 36;
    localparam int X_MAX = 624;
    localparam int Y_MAX = 464;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       clean_en = 1'b0;
    logic [2:0] graph_rgb;
    logic [9:0] robot_x;
    logic [9:0] robot_y;
    logic       frame_tick;
    logic       blocked;

    graphics_robot dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .dir_valid  (dir_valid),
        .dir        (dir),
        .clean_en   (clean_en),
        .graph_rgb  (graph_rgb),
        .robot_x    (robot_x),
        .robot_y    (robot_y),
        .frame_tick (frame_tick),
        .blocked    (blocked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rgb;
        int tick;
        int x;
        int y;
        int blk;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;

    // Reference model state: what the robot should be doing after each clock.
    int m_x, m_y, m_blk, m_blink, m_pv, m_pd, m_tick, m_cond_d;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 64; m_y = 232; m_blk = 0; m_blink = 0;
        m_pv = 0; m_pd = 0; m_tick = 0; m_cond_d = 0;
    endtask

    task automatic model_move(input int d);
        int c;
        case (d)
            0: begin c = m_x + 2; if (c > X_MAX) begin m_x = X_MAX; m_blk = 1; end else begin m_x = c; m_blk = 0; end end
            1: begin c = m_x - 2; if (c < X_MIN) begin m_x = X_MIN; m_blk = 1; end else begin m_x = c; m_blk = 0; end end
            2: begin c = m_y + 2; if (c > Y_MAX) begin m_y = Y_MAX; m_blk = 1; end else begin m_y = c; m_blk = 0; end end
            default: begin c = m_y - 2; if (c < 0) begin m_y = 0; m_blk = 1; end else begin m_y = c; m_blk = 0; end end
        endcase
    endtask

    function automatic int exp_colour(input bit vo, input int px, input int py, input bit ce);
        if (!vo) return 0;
        if (px >= m_x && px < m_x + 16 && py >= m_y && py < m_y + 16)
            return (ce && m_blink >= 8) ? 2 : 4;
        if (px >= 32 && px <= 35) return 1;
        return 6;
    endfunction

    // One clock of stimulus, entered and left at a falling edge.
    task automatic step(input bit vo, input logic [9:0] px, input logic [9:0] py,
                        input bit dv, input logic [1:0] d);
        exp_t e;
        bit   cond;
        video_on  = vo;
        pix_x     = px;
        pix_y     = py;
        dir_valid = dv;
        dir       = d;
        e.rgb = exp_colour(vo, int'(px), int'(py), clean_en);
        cond  = (px == 10'd0) && (py == 10'd480);
        if (m_tick != 0) begin
            if (m_pv != 0) model_move(m_pd);
            m_pv = 0;
        end
        if (dv) begin m_pv = 1; m_pd = int'(d); end
        if (!clean_en) m_blink = 0;
        else if (m_tick != 0) m_blink = (m_blink + 1) % 16;
        m_tick   = (cond && m_cond_d == 0) ? 1 : 0;
        m_cond_d = cond ? 1 : 0;
        e.tick = m_tick; e.x = m_x; e.y = m_y; e.blk = m_blk;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rand_pix();
        logic [9:0] px, py;
        int r;
        r = int'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0: begin px = 10'(m_x + r); py = 10'(m_y + int'($urandom_range(0, 15))); end
            1: begin px = 10'(32 + r % 4); py = 10'($urandom_range(0, 479)); end
            2: begin px = 10'($urandom_range(1, 639)); py = 10'($urandom_range(0, 479)); end
            default: begin px = 10'(m_x - 1 + (r % 2) * 17); py = 10'(m_y + r); end
        endcase
        step($urandom_range(0, 7) != 0, px, py, 1'b0, 2'b00);
    endtask

    // Command (optional), some pixels, then the tick position held two clocks.
    task automatic frame(input bit cv, input logic [1:0] cd, input int npix,
                         input bit coinc, input logic [1:0] cdir);
        step(1'b1, 10'd100, 10'd100, cv, cd);
        for (int i = 0; i < npix; i++) rand_pix();
        step(1'b0, 10'd0, 10'd480, 1'b0, 2'b00);
        step(1'b0, 10'd0, 10'd480, coinc, cdir);
        step(1'b0, 10'd5, 10'd480, 1'b0, 2'b00);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        dir_valid = 1'b0;
        #1;
        check_val("reset_rgb", int'(graph_rgb), 0);
        check_val("reset_x", int'(robot_x), 64);
        check_val("reset_y", int'(robot_y), 232);
        check_val("reset_blocked", int'(blocked), 0);
        check_val("reset_tick", int'(frame_tick), 0);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one line per transaction, compares against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                txn++;
                $display("txn %0d: rgb=%0d tick=%0d x=%0d y=%0d blk=%0d", txn,
                         graph_rgb, frame_tick, robot_x, robot_y, blocked);
                check_val("graph_rgb", int'(graph_rgb), e.rgb);
                check_val("frame_tick", int'(frame_tick), e.tick);
                check_val("robot_x", int'(robot_x), e.x);
                check_val("robot_y", int'(robot_y), e.y);
                check_val("blocked", int'(blocked), e.blk);
                check_val("x_outside_wall", int'(robot_x >= 10'd32 && robot_x <= 10'd35), 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        // First pixel after release lands on the robot.
        step(1'b1, 10'd70, 10'd240, 1'b0, 2'b00);
        step(1'b1, 10'd33, 10'd100, 1'b0, 2'b00);
        step(1'b1, 10'd100, 10'd100, 1'b0, 2'b00);
        step(1'b0, 10'd100, 10'd100, 1'b0, 2'b00);
        frame(1'b1, 2'b00, 3, 1'b0, 2'b00);
        frame(1'b0, 2'b00, 3, 1'b0, 2'b00);
        for (int i = 0; i < 18; i++) frame(1'b1, 2'b01, 1, 1'b0, 2'b00);
        for (int i = 0; i < 120; i++) frame(1'b1, 2'b11, 1, 1'b0, 2'b00);
        for (int i = 0; i < 236; i++) frame(1'b1, 2'b10, 1, 1'b0, 2'b00);
        for (int i = 0; i < 6; i++) frame(1'b1, 2'b11, 1, 1'b0, 2'b00);
        // Two commands in one frame: the later one wins.
        step(1'b1, 10'd200, 10'd200, 1'b1, 2'b00);
        frame(1'b1, 2'b10, 2, 1'b0, 2'b00);
        // Command coincident with the tick is held for the following frame.
        frame(1'b0, 2'b00, 2, 1'b1, 2'b00);
        frame(1'b0, 2'b00, 2, 1'b0, 2'b00);
        clean_en = 1'b1;
        for (int i = 0; i < 34; i++) begin
            step(1'b1, 10'(m_x + 3), 10'(m_y + 3), 1'b0, 2'b00);
            frame(1'b0, 2'b00, 2, 1'b0, 2'b00);
        end
        step(1'b1, 10'(m_x + 3), 10'(m_y + 3), 1'b0, 2'b00);
        clean_en = 1'b0;
        step(1'b1, 10'(m_x + 3), 10'(m_y + 3), 1'b0, 2'b00);
        step(1'b1, 10'(m_x + 3), 10'(m_y + 3), 1'b0, 2'b00);
        for (int i = 0; i < 200; i++) begin
            clean_en = ($urandom_range(0, 3) != 0);
            frame($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  int'($urandom_range(1, 4)), $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
            if (i == 100) begin
                rand_pix();
                do_reset();
                step(1'b1, 10'd70, 10'd240, 1'b0, 2'b00);
            end
        end
        step(1'b0, 10'd5, 10'd5, 1'b0, 2'b00);
        step(1'b0, 10'd5, 10'd5, 1'b0, 2'b00);
        check_val("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
